// File: rtl/pipeline_exec_ctrl_if.sv
// Host-side bundle for the pipeline execution controller.
//   Command channel : i_cmd_valid / i_cmd / o_cmd_ready
//   Report channel  : o_done_valid / o_done_halt / i_done_ready
//   Pipeline side   : i_WB_halt in, o_pipe_enable / o_pipe_flush out
//   Status          : o_cycle_count (CYCLE_W bits), o_state (3 bits)
// The slave modport is the controller; the master modport is the host side.
interface pipeline_exec_ctrl_if #(
  parameter int CYCLE_W = 32
) ();
  logic               i_cmd_valid;
  logic [1:0]         i_cmd;
  logic               o_cmd_ready;
  logic               i_WB_halt;
  logic               o_pipe_enable;
  logic               o_pipe_flush;
  logic               o_done_valid;
  logic               o_done_halt;
  logic               i_done_ready;
  logic [CYCLE_W-1:0] o_cycle_count;
  logic [2:0]         o_state;

  modport slave (
    input  i_cmd_valid, i_cmd, i_WB_halt, i_done_ready,
    output o_cmd_ready, o_pipe_enable, o_pipe_flush, o_done_valid,
           o_done_halt, o_cycle_count, o_state
  );

  modport master (
    output i_cmd_valid, i_cmd, i_WB_halt, i_done_ready,
    input  o_cmd_ready, o_pipe_enable, o_pipe_flush, o_done_valid,
           o_done_halt, o_cycle_count, o_state
  );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller: sequences the pipeline global enable/flush under
// debug-host RUN / STEP / CLEAR commands, detects HALT retirement at WB,
// counts enabled cycles (saturating) and reports completion to the host.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : pipeline_exec_ctrl_if.slave (command, report, pipeline, status)
// All outputs are decoded from registered state; no input-to-output paths.
module pipeline_exec_ctrl #(
  parameter int CYCLE_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pipeline_exec_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    REPORT = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [CYCLE_W-1:0] CNT_MAX = '1;
  localparam logic [CYCLE_W-1:0] CNT_ONE = {{(CYCLE_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic               done_halt;
  logic               flush;
  logic [CYCLE_W-1:0] cycle_count;

  logic pipe_enable;
  logic cmd_ready;
  logic cmd_accept;
  logic clr_accept;

  assign pipe_enable = (state == RUN) || (state == STEP);
  assign cmd_ready   = (state == IDLE) || (state == RUN) || (state == HALTED);
  assign cmd_accept  = bus.i_cmd_valid && cmd_ready;
  // CLEAR can only be accepted in IDLE, RUN or HALTED; in all three it
  // flushes, zeroes the counter and returns to IDLE.
  assign clr_accept  = cmd_accept && (bus.i_cmd == CMD_CLEAR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      done_halt   <= 1'b0;
      flush       <= 1'b0;
      cycle_count <= '0;
    end else begin
      flush <= 1'b0;

      if (pipe_enable && (cycle_count != CNT_MAX))
        cycle_count <= cycle_count + CNT_ONE;

      // Placed after the increment so CLEAR wins in the same cycle.
      if (clr_accept) begin
        flush       <= 1'b1;
        cycle_count <= '0;
      end

      unique case (state)
        IDLE: begin
          if (cmd_accept && (bus.i_cmd == CMD_RUN))
            state <= RUN;
          else if (cmd_accept && (bus.i_cmd == CMD_STEP))
            state <= STEP;
        end
        RUN: begin
          // Abort beats a coincident halt: no report is produced.
          if (clr_accept) begin
            state <= IDLE;
          end else if (bus.i_WB_halt) begin
            state     <= REPORT;
            done_halt <= 1'b1;
          end
        end
        STEP: begin
          state     <= REPORT;
          done_halt <= bus.i_WB_halt;
        end
        REPORT: begin
          if (bus.i_done_ready) begin
            state     <= done_halt ? HALTED : IDLE;
            done_halt <= 1'b0;
          end
        end
        HALTED: begin
          if (clr_accept)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_state       = state;
  assign bus.o_pipe_enable = pipe_enable;
  assign bus.o_pipe_flush  = flush;
  assign bus.o_done_valid  = (state == REPORT);
  assign bus.o_done_halt   = done_halt;
  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Testbench for pipeline_exec_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the controller.
module tb_pipeline_exec_ctrl;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic i_clk;
  logic i_reset;

  pipeline_exec_ctrl_if #(.CYCLE_W(CW)) bus ();

  pipeline_exec_ctrl #(.CYCLE_W(CW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp;
  int n_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state uses the documented debug codes; the counter is an
  // unbounded integer and saturation is applied only when read.
  int m_st;
  int m_cnt;
  bit m_halt_flag;
  bit m_flush;
  bit model_on;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  always @(negedge i_clk) begin
    bit en, rdy, acc, clr;
    if (model_on) begin
      cmp("m_state",   bus.o_state,         m_st);
      cmp("m_enable",  bus.o_pipe_enable,   (m_st == 1 || m_st == 2));
      cmp("m_flush",   bus.o_pipe_flush,    m_flush);
      cmp("m_dvalid",  bus.o_done_valid,    (m_st == 3));
      cmp("m_ready",   bus.o_cmd_ready,     (m_st == 0 || m_st == 1 || m_st == 4));
      cmp("m_count",   bus.o_cycle_count,   sat(m_cnt));
      if (m_st == 3)
        cmp("m_dhalt", bus.o_done_halt, m_halt_flag);
    end
    if (i_reset) begin
      m_st = 0; m_cnt = 0; m_halt_flag = 0; m_flush = 0;
      model_on = 1;
    end else if (model_on) begin
      en  = (m_st == 1 || m_st == 2);
      rdy = (m_st == 0 || m_st == 1 || m_st == 4);
      acc = bus.i_cmd_valid && rdy;
      clr = acc && (bus.i_cmd == 2'b11);
      m_flush = 0;
      if (en) m_cnt++;
      if (clr) begin
        m_flush = 1; m_cnt = 0; m_st = 0;
      end else begin
        case (m_st)
          0: if (acc && bus.i_cmd == 2'b01) m_st = 1;
             else if (acc && bus.i_cmd == 2'b10) m_st = 2;
          1: if (bus.i_WB_halt) begin m_st = 3; m_halt_flag = 1; end
          2: begin m_st = 3; m_halt_flag = bus.i_WB_halt; end
          3: if (bus.i_done_ready) m_st = m_halt_flag ? 4 : 0;
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    cyc();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = 2'b00;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_on = 0;
    i_reset          = 1'b1;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = 2'b00;
    bus.i_WB_halt    = 1'b0;
    bus.i_done_ready = 1'b0;

    // Reset then idle
    cyc(); cyc();
    i_reset = 1'b0;
    cmp("rst_state", bus.o_state, 0);
    cmp("rst_ready", bus.o_cmd_ready, 1);
    cmp("rst_en",    bus.o_pipe_enable, 0);
    cmp("rst_cnt",   bus.o_cycle_count, 0);
    cmp("rst_flush", bus.o_pipe_flush, 0);
    cyc();
    cmp("idle_flush", bus.o_pipe_flush, 0);

    // Single step without halt
    send(2'b10);
    cmp("step_en1",   bus.o_pipe_enable, 1);
    cmp("step_ready", bus.o_cmd_ready, 0);
    cyc();
    cmp("step_en0",   bus.o_pipe_enable, 0);
    cmp("step_cnt",   bus.o_cycle_count, 1);
    cmp("step_dv1",   bus.o_done_valid, 1);
    cmp("step_dh",    bus.o_done_halt, 0);
    cyc();
    cmp("step_dv2",   bus.o_done_valid, 1);
    cyc();
    cmp("step_dv3",   bus.o_done_valid, 1);
    bus.i_done_ready = 1'b1;
    cyc();
    bus.i_done_ready = 1'b0;
    cmp("step_idle",  bus.o_state, 0);
    cmp("step_dv0",   bus.o_done_valid, 0);

    // Run to halt on the 10th enabled cycle
    send(2'b11);
    cmp("clr_flush", bus.o_pipe_flush, 1);
    cmp("clr_cnt",   bus.o_cycle_count, 0);
    send(2'b01);
    for (int k = 0; k < 9; k++) cyc();
    bus.i_WB_halt = 1'b1;
    cyc();
    bus.i_WB_halt = 1'b0;
    cmp("halt_cnt",   bus.o_cycle_count, 10);
    cmp("halt_en",    bus.o_pipe_enable, 0);
    cmp("halt_dv",    bus.o_done_valid, 1);
    cmp("halt_dh",    bus.o_done_halt, 1);
    bus.i_done_ready = 1'b1;
    cyc();
    bus.i_done_ready = 1'b0;
    cmp("halted_st",  bus.o_state, 4);
    send(2'b01);
    cmp("halted_run_st", bus.o_state, 4);
    cmp("halted_run_en", bus.o_pipe_enable, 0);

    // Clear from HALTED, then RUN restarts the pipeline
    send(2'b11);
    cmp("hclr_flush", bus.o_pipe_flush, 1);
    cmp("hclr_cnt",   bus.o_cycle_count, 0);
    cmp("hclr_st",    bus.o_state, 0);
    cyc();
    cmp("hclr_pulse", bus.o_pipe_flush, 0);
    send(2'b01);
    cmp("rerun_en",   bus.o_pipe_enable, 1);

    // CLEAR colliding with halt while running
    cyc();
    bus.i_WB_halt = 1'b1;
    send(2'b11);
    bus.i_WB_halt = 1'b0;
    cmp("coll_st",    bus.o_state, 0);
    cmp("coll_flush", bus.o_pipe_flush, 1);
    cmp("coll_dv",    bus.o_done_valid, 0);
    cyc();
    cmp("coll_dv2",   bus.o_done_valid, 0);

    // Saturation, then mid-run reset
    send(2'b01);
    for (int k = 0; k < 19; k++) cyc();
    cmp("sat_cnt", bus.o_cycle_count, 15);
    cmp("sat_en",  bus.o_pipe_enable, 1);
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    cmp("mrst_st",    bus.o_state, 0);
    cmp("mrst_en",    bus.o_pipe_enable, 0);
    cmp("mrst_flush", bus.o_pipe_flush, 0);
    cmp("mrst_dv",    bus.o_done_valid, 0);
    cmp("mrst_dh",    bus.o_done_halt, 0);
    cmp("mrst_cnt",   bus.o_cycle_count, 0);
    cmp("mrst_ready", bus.o_cmd_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_reset          = ($urandom_range(0, 199) == 0);
      bus.i_cmd_valid  = ($urandom_range(0, 3) == 0);
      bus.i_cmd        = 2'($urandom_range(0, 3));
      bus.i_WB_halt    = ($urandom_range(0, 15) == 0);
      bus.i_done_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end
    i_reset         = 1'b0;
    bus.i_cmd_valid = 1'b0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
